seg_scan_decoder: RTL and testbench

//  Inverse of the hex-to-7-segment encoder: snoops a time-multiplexed 7-segment

---
 rtl/seg_scan_decoder.sv | 138 +++++++++++++
 tb/tb_seg_scan_decoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers hex digit values from a snooped, time-multiplexed
// 7-segment display bus. Each digit has its own candidate/count filter so that
// ghost patterns seen around scan transitions are never committed.
module seg_scan_decoder #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    sample_en,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   digit_ok,
  output logic                    upd,
  output logic                    err_sel
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

  // {valid, value}: inverse of the standard hex-to-7-segment table
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b1111110: seg_decode = {1'b1, 4'h0};
      7'b0110000: seg_decode = {1'b1, 4'h1};
      7'b1101101: seg_decode = {1'b1, 4'h2};
      7'b1111001: seg_decode = {1'b1, 4'h3};
      7'b0110011: seg_decode = {1'b1, 4'h4};
      7'b1011011: seg_decode = {1'b1, 4'h5};
      7'b1011111: seg_decode = {1'b1, 4'h6};
      7'b1110000: seg_decode = {1'b1, 4'h7};
      7'b1111111: seg_decode = {1'b1, 4'h8};
      7'b1111011: seg_decode = {1'b1, 4'h9};
      7'b1110111: seg_decode = {1'b1, 4'hA};
      7'b0011111: seg_decode = {1'b1, 4'hB};
      7'b1001110: seg_decode = {1'b1, 4'hC};
      7'b0111101: seg_decode = {1'b1, 4'hD};
      7'b1001111: seg_decode = {1'b1, 4'hE};
      7'b1000111: seg_decode = {1'b1, 4'hF};
      default:    seg_decode = 5'b0;
    endcase
  endfunction

  logic [6:0]            seg_p0;
  logic [NUM_DIGITS-1:0] sel_p0;
  logic                  vld_p0;

  logic [6:0]       cand   [NUM_DIGITS];
  logic [CNT_W-1:0] cnt    [NUM_DIGITS];
  logic [6:0]       cand_n [NUM_DIGITS];
  logic [CNT_W-1:0] cnt_n  [NUM_DIGITS];

  logic [4*NUM_DIGITS-1:0] hex_n;
  logic [NUM_DIGITS-1:0]   ok_n;
  logic                    upd_n;
  logic                    err_n;
  logic                    sel_onehot;

  // ---- stage 0: input capture ----
  // Bus snapshot; only the strobe needs reset so queued samples die with it
  always_ff @(posedge clk) begin
    seg_p0 <= seg_in;
    sel_p0 <= dig_sel;
  end

  // Sample strobe register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= sample_en;
  end

  assign sel_onehot = (sel_p0 != '0) &&
                      ((sel_p0 & (sel_p0 - NUM_DIGITS'(1))) == '0);

  // ---- stage 1: per-digit stability filter and commit ----
  // Next filter state and committed outputs for the registered sample
  always_comb begin
    logic       commit;
    logic [4:0] dec;
    cand_n = cand;
    cnt_n  = cnt;
    hex_n  = hex_out;
    ok_n   = digit_ok;
    err_n  = 1'b0;
    commit = 1'b0;
    dec    = seg_decode(seg_p0);
    if (vld_p0) begin
      if (!sel_onehot) begin
        err_n = 1'b1;
      end else begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          commit = 1'b0;
          if (sel_p0[i]) begin
            if (seg_p0 == cand[i]) begin
              // Saturated count means already committed: hold, no re-commit
              if (cnt[i] != CNT_MAX) begin
                cnt_n[i] = cnt[i] + 4'd1;
                commit   = ((cnt[i] + 4'd1) == CNT_MAX);
              end
            end else begin
              cand_n[i] = seg_p0;
              cnt_n[i]  = 4'd1;
              commit    = (CNT_MAX == 4'd1);
            end
            if (commit) begin
              ok_n[i] = dec[4];
              if (dec[4]) hex_n[4*i +: 4] = dec[3:0];
            end
          end
        end
      end
    end
    upd_n = (hex_n != hex_out) || (ok_n != digit_ok);
  end

  // Filter state, committed outputs and event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        cand[i] <= 7'b0;
        cnt[i]  <= '0;
      end
      hex_out  <= '0;
      digit_ok <= '0;
      upd      <= 1'b0;
      err_sel  <= 1'b0;
    end else begin
      cand     <= cand_n;
      cnt      <= cnt_n;
      hex_out  <= hex_n;
      digit_ok <= ok_n;
      upd      <= upd_n;
      err_sel  <= err_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: vector table with two-cycle-delayed
// expectations plus hand sequences for reset and the STABLE_CNT=1 variant.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = 7'b0;
  logic [3:0]  dig_sel = 4'b0;
  logic        sample_en = 1'b0;

  logic [15:0] hex_out,  hex1;
  logic [3:0]  digit_ok, ok1;
  logic        upd, upd1, err_sel, err1;

  int n_vec = 0;
  int n_bad = 0;

  seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CNT(3)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel),
    .sample_en(sample_en), .hex_out(hex_out), .digit_ok(digit_ok),
    .upd(upd), .err_sel(err_sel));

  seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CNT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel),
    .sample_en(sample_en), .hex_out(hex1), .digit_ok(ok1),
    .upd(upd1), .err_sel(err1));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [6:0]  seg;
    logic        en;
    logic [15:0] hex;
    logic [3:0]  ok;
    logic        upd;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  logic [6:0] code_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  localparam logic [6:0] BAD = 7'b1010101;

  task automatic add(input logic [3:0] sel, input logic [6:0] seg, input logic en,
                     input logic [15:0] hex, input logic [3:0] ok,
                     input logic u, input logic e);
    vec_t v;
    v.sel = sel; v.seg = seg; v.en = en; v.hex = hex; v.ok = ok; v.upd = u; v.err = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name,
                       input logic [15:0] ah, input logic [3:0] ao, input logic au, input logic ae,
                       input logic [15:0] eh, input logic [3:0] eo, input logic eu, input logic ee);
    n_vec++;
    if (ah !== eh || ao !== eo || au !== eu || ae !== ee) begin
      n_bad++;
      $display("FAIL %s: got hex=%h ok=%b upd=%b err=%b, want hex=%h ok=%b upd=%b err=%b",
               name, ah, ao, au, ae, eh, eo, eu, ee);
    end
  endtask

  task automatic step(input logic [3:0] sel, input logic [6:0] seg, input logic en);
    @(posedge clk);
    #1;
    dig_sel = sel; seg_in = seg; sample_en = en;
  endtask

  initial begin
    logic [15:0] mh;
    logic [3:0]  mo;
    logic [15:0] nh;
    logic [3:0]  cA, c0, c1, c3, c5, c7, cC, cF;
    int nv;

    cA = 4'hA; c0 = 4'h0; c1 = 4'h1; c3 = 4'h3; c5 = 4'h5; c7 = 4'h7; cC = 4'hC; cF = 4'hF;

    // digit 0: A committed on 3rd sample, 4th is silent
    add(4'b0001, code_tab[cA], 1, 16'h0000, 4'b0000, 0, 0);
    add(4'b0001, code_tab[cA], 1, 16'h0000, 4'b0000, 0, 0);
    add(4'b0001, code_tab[cA], 1, 16'h000A, 4'b0001, 1, 0);
    add(4'b0001, code_tab[cA], 1, 16'h000A, 4'b0001, 0, 0);
    // digit 1 ghosting: 0,0 then 1,1,1
    add(4'b0010, code_tab[c0], 1, 16'h000A, 4'b0001, 0, 0);
    add(4'b0010, code_tab[c0], 1, 16'h000A, 4'b0001, 0, 0);
    add(4'b0010, code_tab[c1], 1, 16'h000A, 4'b0001, 0, 0);
    add(4'b0010, code_tab[c1], 1, 16'h000A, 4'b0001, 0, 0);
    add(4'b0010, code_tab[c1], 1, 16'h001A, 4'b0011, 1, 0);
    // digit 2: 5 committed, then invalid pattern clears ok but keeps value
    add(4'b0100, code_tab[c5], 1, 16'h001A, 4'b0011, 0, 0);
    add(4'b0100, code_tab[c5], 1, 16'h001A, 4'b0011, 0, 0);
    add(4'b0100, code_tab[c5], 1, 16'h051A, 4'b0111, 1, 0);
    add(4'b0100, BAD,          1, 16'h051A, 4'b0111, 0, 0);
    add(4'b0100, BAD,          1, 16'h051A, 4'b0111, 0, 0);
    add(4'b0100, BAD,          1, 16'h051A, 4'b0011, 1, 0);
    add(4'b0100, BAD,          1, 16'h051A, 4'b0011, 0, 0);
    add(4'b1111, 7'h7F,        0, 16'h051A, 4'b0011, 0, 0);
    // bad selects in the middle of a digit-3 build-up
    add(4'b1000, code_tab[cF], 1, 16'h051A, 4'b0011, 0, 0);
    add(4'b0011, code_tab[cF], 1, 16'h051A, 4'b0011, 0, 1);
    add(4'b0000, code_tab[cF], 1, 16'h051A, 4'b0011, 0, 1);
    add(4'b1111, code_tab[cF], 1, 16'h051A, 4'b0011, 0, 1);
    add(4'b1000, code_tab[cF], 1, 16'h051A, 4'b0011, 0, 0);
    add(4'b1000, code_tab[cF], 1, 16'hF51A, 4'b1011, 1, 0);
    // interleaved scan of 3,7,C,F for three rounds
    for (int r = 0; r < 2; r++) begin
      add(4'b0001, code_tab[c3], 1, 16'hF51A, 4'b1011, 0, 0);
      add(4'b0010, code_tab[c7], 1, 16'hF51A, 4'b1011, 0, 0);
      add(4'b0100, code_tab[cC], 1, 16'hF51A, 4'b1011, 0, 0);
      add(4'b1000, code_tab[cF], 1, 16'hF51A, 4'b1011, 0, 0);
    end
    add(4'b0001, code_tab[c3], 1, 16'hF513, 4'b1011, 1, 0);
    add(4'b0010, code_tab[c7], 1, 16'hF573, 4'b1011, 1, 0);
    add(4'b0100, code_tab[cC], 1, 16'hFC73, 4'b1111, 1, 0);
    add(4'b1000, code_tab[cF], 1, 16'hFC73, 4'b1111, 0, 0);
    // full code sweep on every digit
    mh = 16'hFC73; mo = 4'hF;
    for (int c = 0; c < 16; c++) begin
      for (int d = 0; d < 4; d++) begin
        add(4'b0001 << d, code_tab[c], 1, mh, mo, 0, 0);
        add(4'b0001 << d, code_tab[c], 1, mh, mo, 0, 0);
        nh = mh;
        nh[4*d +: 4] = 4'(c);
        add(4'b0001 << d, code_tab[c], 1, nh, mo, nh != mh, 0);
        mh = nh;
      end
    end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_s3", hex_out, digit_ok, upd, err_sel, 16'h0, 4'h0, 0, 0);
    check("reset_s1", hex1, ok1, upd1, err1, 16'h0, 4'h0, 0, 0);
    rst_n = 1'b1;

    nv = vecs.size();
    for (int k = 0; k < nv + 2; k++) begin
      @(posedge clk);
      #1;
      if (k >= 2)
        check($sformatf("vec%0d", k - 2), hex_out, digit_ok, upd, err_sel,
              vecs[k-2].hex, vecs[k-2].ok, vecs[k-2].upd, vecs[k-2].err);
      if (k < nv) begin
        dig_sel = vecs[k].sel; seg_in = vecs[k].seg; sample_en = vecs[k].en;
      end else begin
        sample_en = 1'b0;
      end
    end

    // reset between 2nd and 3rd sample of a new value
    step(4'b0001, code_tab[c5], 1);
    step(4'b0001, code_tab[c5], 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0; sample_en = 1'b0;
    #1;
    check("rst_mid_s3", hex_out, digit_ok, upd, err_sel, 16'h0, 4'h0, 0, 0);
    check("rst_mid_s1", hex1, ok1, upd1, err1, 16'h0, 4'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b0000, 7'b0, 0);
    step(4'b0000, 7'b0, 0);
    check("rst_discard", hex_out, digit_ok, upd, err_sel, 16'h0, 4'h0, 0, 0);
    step(4'b0001, code_tab[c5], 1);
    step(4'b0000, 7'b0, 0);
    step(4'b0000, 7'b0, 0);
    check("post_rst_1st", hex_out, digit_ok, upd, err_sel, 16'h0, 4'h0, 0, 0);
    check("s1_immediate", hex1, ok1, upd1, err1, 16'h0005, 4'b0001, 1, 0);
    step(4'b0001, code_tab[c5], 1);
    step(4'b0001, code_tab[c5], 1);
    step(4'b0000, 7'b0, 0);
    step(4'b0000, 7'b0, 0);
    check("post_rst_3rd", hex_out, digit_ok, upd, err_sel, 16'h0005, 4'b0001, 1, 0);
    check("s1_no_recommit", hex1, ok1, upd1, err1, 16'h0005, 4'b0001, 0, 0);
    step(4'b0000, 7'b0, 0);
    check("upd_one_cycle", hex_out, digit_ok, upd, err_sel, 16'h0005, 4'b0001, 0, 0);

    // STABLE_CNT=1 build: every new valid sample commits at once
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b0010, code_tab[c7], 1);
    step(4'b0000, 7'b0, 0);
    step(4'b0000, 7'b0, 0);
    check("s1_d1_7", hex1, ok1, upd1, err1, 16'h0070, 4'b0010, 1, 0);
    check("s3_d1_7", hex_out, digit_ok, upd, err_sel, 16'h0, 4'h0, 0, 0);
    step(4'b0010, code_tab[4'h9], 1);
    step(4'b0000, 7'b0, 0);
    step(4'b0000, 7'b0, 0);
    check("s1_d1_9", hex1, ok1, upd1, err1, 16'h0090, 4'b0010, 1, 0);
    step(4'b0010, 7'b0, 1);
    step(4'b0000, 7'b0, 0);
    step(4'b0000, 7'b0, 0);
    check("s1_blank", hex1, ok1, upd1, err1, 16'h0090, 4'b0000, 1, 0);
    step(4'b0101, 7'b0, 1);
    step(4'b0000, 7'b0, 0);
    step(4'b0000, 7'b0, 0);
    check("s1_err", hex1, ok1, upd1, err1, 16'h0090, 4'b0000, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
